mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads, 10 bytes) and the memory stage (8-byte data read/write).
- Sequences each variable-latency bus transaction with a small FSM and returns data or error to the requester.
- Drives f_wait_o / m_wait_o into pipeline_control so it can stall or bubble while memory is busy.

Parameters:
- ADDR_W, 64, address width
- TIMEOUT, 255, bus cycles without mem_ready_i before the transaction aborts with error

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- f_req_i  in  1  fetch request; held until f_valid_o
- f_addr_i  in  ADDR_W  fetch PC
- f_flush_i  in  1  discard outstanding fetch (mispredict/ret)
- f_instr_o  out  80  instruction bytes, byte0 in [7:0]
- f_valid_o  out  1  one-cycle fetch completion pulse
- f_err_o  out  1  fetch error, qualified by f_valid_o
- f_wait_o  out  1  fetch stalled = f_req_i & ~f_valid_o
- m_req_i  in  1  data request; held until m_valid_o
- m_we_i  in  1  1 = write
- m_addr_i  in  ADDR_W  data address
- m_wdata_i  in  64  write data
- m_rdata_o  out  64  read data
- m_valid_o  out  1  one-cycle data completion pulse
- m_err_o  out  1  data error (maps to SADR), qualified by m_valid_o
- m_wait_o  out  1  = m_req_i & ~m_valid_o
- mem_req_o  out  1  bus request, high for the whole transaction
- mem_we_o  out  1  bus write enable
- mem_addr_o  out  ADDR_W  bus address
- mem_wdata_o  out  64  bus write data
- mem_rdata_i  in  80  bus read data; data reads use [63:0]
- mem_ready_i  in  1  transaction complete
- mem_err_i  in  1  bus error, qualified by mem_ready_i

Behaviour:
- Reset (asynchronous, immediate):
  - State returns to IDLE; every output register goes to 0, including the bus and data outputs.
  - mem_req_o drops at once, even mid-transaction.
  - last_m clears to 0.
- States:
  - IDLE: no transaction in flight.
  - BUSY_F: fetch transaction in flight.
  - BUSY_M: data transaction in flight.
  - No separate response state; valid pulses are registered.
- Eligible requests in IDLE:
  - f_elig = f_req_i & ~f_valid_o & ~f_flush_i.
  - m_elig = m_req_i & ~m_valid_o.
  - In the valid cycle the requester's req is still high and stale, so it is masked out.
- Arbitration in IDLE:
  - Both eligible: M wins unless last_m = 1, then F wins (no F starvation).
  - Only one eligible: that one wins.
  - last_m updates on every grant: 1 for M, 0 for F.
- On grant:
  - Latch address, we and wdata into the bus registers; set mem_req_o = 1 from the next cycle.
  - Go to BUSY_x and clear the timeout counter.
- BUSY_x:
  - mem_req_o and the bus registers stay stable.
  - The counter increments each cycle that mem_ready_i = 0.
- mem_ready_i = 1 in BUSY_x:
  - Next cycle: x_valid_o = 1, state IDLE, mem_req_o = 0.
  - Data register captures mem_rdata_i; it is zeroed if mem_err_i.
  - x_err_o = mem_err_i.
  - Writes return m_rdata_o = 0.
- Minimum latency: request to valid is 2 cycles with a 0-wait bus (grant cycle, then ready in first BUSY cycle; valid the cycle after).
- Timeout: counter = TIMEOUT with no ready → abort as if mem_ready_i & mem_err_i (valid + err); mem_req_o drops.
- Flush:
  - f_flush_i in BUSY_F sets a drop flag. The bus transaction still runs to completion; on completion there is no f_valid_o and no data update.
  - f_flush_i in IDLE only blocks the F grant that cycle.
  - Flush never affects an M transaction.
- f_valid_o and m_valid_o are never high in the same cycle.
- Outputs other than the valid pulses hold their last value.

Decomposition:
- In define.v:
  - FSM state encodings ARB_IDLE, ARB_BUSY_F, ARB_BUSY_M (2-bit).
  - Instruction width constant (80).
  - Existing SADR status code, used downstream for m_err_o / f_err_o mapping.
- One sub-module, mem_timeout_ctr: clear/enable inputs, expired output, parameter TIMEOUT, 8-bit width, saturates.

Test Plan:
- Fetch only, f_addr=0x100, ready on 1st BUSY cycle, rdata=0x30F2_0A00_0000_0000_0000 → f_valid at cycle 2 with that f_instr; f_wait high cycles 0-1.
- Simultaneous f_req and m_req (m_we=1, addr=0x200, wdata=0xDEAD), last_m=0 → M granted first with mem_we=1, mem_addr=0x200; then F; then with both requesting again, F wins after M.
- Fetch in BUSY_F, f_flush_i pulsed, ready after 3 waits → no f_valid_o, f_instr unchanged; next F request is granted normally.
- Data read, mem_err_i=1 with ready → m_valid=1, m_err=1, m_rdata=0.
- mem_ready never asserted, TIMEOUT=4 → abort with m_valid=1 and m_err=1 after the 4th wait cycle; mem_req_o low next cycle.
- rst_n low during BUSY_M → mem_req_o and all valids 0 immediately; after release, a new F request proceeds from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// The FSM state encodings, the instruction width and the SADR status code live here.
package mem_port_arbiter_pkg;

  localparam int INSTR_W = 80;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 8;

  // Status code raised downstream when f_err_o / m_err_o is set.
  localparam logic [3:0] SADR = 4'h3;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_F = 2'd1,
    ARB_BUSY_M = 2'd2
  } arb_state_e;

  // Data wins a tie unless it took the previous grant.
  function automatic logic pick_m(input logic f_elig, input logic m_elig, input logic last_m);
    return m_elig & (~f_elig | ~last_m);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and bus signals of the memory port arbiter.
// The arb modport is the arbiter's view; env is the pipeline/memory side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64
);
  logic               f_req_i;
  logic [ADDR_W-1:0]  f_addr_i;
  logic               f_flush_i;
  logic [INSTR_W-1:0] f_instr_o;
  logic               f_valid_o;
  logic               f_err_o;
  logic               f_wait_o;

  logic               m_req_i;
  logic               m_we_i;
  logic [ADDR_W-1:0]  m_addr_i;
  logic [DATA_W-1:0]  m_wdata_i;
  logic [DATA_W-1:0]  m_rdata_o;
  logic               m_valid_o;
  logic               m_err_o;
  logic               m_wait_o;

  logic               mem_req_o;
  logic               mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [DATA_W-1:0]  mem_wdata_o;
  logic [INSTR_W-1:0] mem_rdata_i;
  logic               mem_ready_i;
  logic               mem_err_i;

  modport arb (
    input  f_req_i, f_addr_i, f_flush_i,
    output f_instr_o, f_valid_o, f_err_o, f_wait_o,
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i,
    output m_rdata_o, m_valid_o, m_err_o, m_wait_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i, mem_err_i
  );

  modport env (
    output f_req_i, f_addr_i, f_flush_i,
    input  f_instr_o, f_valid_o, f_err_o, f_wait_o,
    output m_req_i, m_we_i, m_addr_i, m_wdata_i,
    input  m_rdata_o, m_valid_o, m_err_o, m_wait_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i, mem_err_i
  );
endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Saturating wait-cycle counter for one bus transaction.
// expired is high in the wait cycle that brings the count to TIMEOUT.
module mem_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and data access,
// sequencing one variable-latency bus transaction at a time.
//
// state      | meaning
// ARB_IDLE   | no transaction in flight, arbitrate eligible requests
// ARB_BUSY_F | fetch transaction on the bus
// ARB_BUSY_M | data transaction on the bus
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  mem_port_arbiter_if.arb bus
);
  arb_state_e        state;
  logic              last_m;
  logic              drop_f;
  logic              f_elig, m_elig, grant_m, grant_f;
  logic              busy, expired, done, done_err;
  logic [ADDR_W-1:0] addr_sel;

  // A requester's req is still high in its own valid cycle; mask it.
  assign f_elig   = bus.f_req_i & ~bus.f_valid_o & ~bus.f_flush_i;
  assign m_elig   = bus.m_req_i & ~bus.m_valid_o;
  assign grant_m  = (state == ARB_IDLE) & pick_m(f_elig, m_elig, last_m);
  assign grant_f  = (state == ARB_IDLE) & f_elig & ~grant_m;
  assign addr_sel = grant_m ? bus.m_addr_i : bus.f_addr_i;

  assign busy     = (state != ARB_IDLE);
  assign done     = busy & (bus.mem_ready_i | expired);
  assign done_err = bus.mem_ready_i ? bus.mem_err_i : 1'b1;

  assign bus.f_wait_o = bus.f_req_i & ~bus.f_valid_o;
  assign bus.m_wait_o = bus.m_req_i & ~bus.m_valid_o;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (grant_m | grant_f),
    .en      (busy & ~bus.mem_ready_i),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ARB_IDLE;
      last_m          <= 1'b0;
      drop_f          <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.f_instr_o   <= '0;
      bus.f_valid_o   <= 1'b0;
      bus.f_err_o     <= 1'b0;
      bus.m_rdata_o   <= '0;
      bus.m_valid_o   <= 1'b0;
      bus.m_err_o     <= 1'b0;
    end else begin
      bus.f_valid_o <= 1'b0;
      bus.m_valid_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_m || grant_f) begin
            bus.mem_req_o  <= 1'b1;
            bus.mem_addr_o <= addr_sel;
            last_m         <= grant_m;
          end
          if (grant_m) begin
            bus.mem_we_o    <= bus.m_we_i;
            bus.mem_wdata_o <= bus.m_wdata_i;
            state           <= ARB_BUSY_M;
          end else if (grant_f) begin
            bus.mem_we_o <= 1'b0;
            drop_f       <= 1'b0;
            state        <= ARB_BUSY_F;
          end
        end
        ARB_BUSY_F: begin
          if (bus.f_flush_i) drop_f <= 1'b1;
          if (done) begin
            bus.mem_req_o <= 1'b0;
            state         <= ARB_IDLE;
            // A flushed fetch still finishes on the bus but is discarded.
            if (!(drop_f || bus.f_flush_i)) begin
              bus.f_valid_o <= 1'b1;
              bus.f_err_o   <= done_err;
              bus.f_instr_o <= done_err ? '0 : bus.mem_rdata_i;
            end
          end
        end
        ARB_BUSY_M: begin
          if (done) begin
            bus.mem_req_o <= 1'b0;
            state         <= ARB_IDLE;
            bus.m_valid_o <= 1'b1;
            bus.m_err_o   <= done_err;
            bus.m_rdata_o <= (done_err || bus.mem_we_o) ? '0 : bus.mem_rdata_i[DATA_W-1:0];
          end
        end
        default: begin
          bus.mem_req_o <= 1'b0;
          state         <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
